// File: rtl/instruction_sequencer.sv
// Instruction sequencer: a host loads a small program of {instruction, hold} entries while
// idle, then a start request replays the program onto a registered instruction bus, holding
// each word for hold+1 cycles. Optional feature macro: SEQ_LOOP_EN adds a 'loop' input that
// restarts the program from entry 0 instead of completing.
module instruction_sequencer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IW    = 156,
    parameter int unsigned HW    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [IW-1:0]          wr_instr,
    input  logic [HW-1:0]          wr_hold,
    input  logic                   prog_clear,
    input  logic                   start,
    input  logic                   abort,
`ifdef SEQ_LOOP_EN
    input  logic                   loop,
`endif
    output logic [IW-1:0]          instruction,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] prog_len
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [IW-1:0]     instr_q, instr_d;
    logic              done_q, done_d;
    logic [AW:0]       len_q, len_d;

    logic [IW+HW-1:0]  mem [DEPTH];
    logic [AW-1:0]     rd_idx;
    logic [IW+HW-1:0]  rd_entry;
    logic              is_last;
    logic              wr_fire;

    assign wr_ready = (state_q == StIdle) && (len_q < (AW+1)'(DEPTH));
    // A same-cycle clear discards the write.
    assign wr_fire  = wr_valid && wr_ready && !prog_clear;
    assign is_last  = ({1'b0, ptr_q} == (len_q - (AW+1)'(1)));
    // Entry to load next: 0 when starting or wrapping, otherwise the following index.
    assign rd_idx   = ((state_q == StRun) && !is_last) ? ptr_q + AW'(1) : '0;
    assign rd_entry = mem[rd_idx];

    assign instruction = instr_q;
    assign busy        = (state_q == StRun);
    assign done        = done_q;
    assign prog_len    = len_q;

    // Program storage; contents need no reset since prog_len gates what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[len_q[AW-1:0]] <= {wr_instr, wr_hold};
        end
    end

    // Next-state logic for program loading and execution.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        instr_d = instr_q;
        done_d  = 1'b0;
        len_d   = len_q;
        unique case (state_q)
            StIdle: begin
                instr_d = '0;
                if (prog_clear) begin
                    len_d = '0;
                end else if (wr_fire) begin
                    len_d = len_q + (AW+1)'(1);
                end
                if (start) begin
                    if ((len_q != '0) && !prog_clear) begin
                        state_d = StRun;
                        ptr_d   = '0;
                        instr_d = rd_entry[IW+HW-1:HW];
                        hold_d  = rd_entry[HW-1:0];
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                    hold_d  = '0;
                    instr_d = '0;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (!is_last) begin
                    ptr_d   = rd_idx;
                    instr_d = rd_entry[IW+HW-1:HW];
                    hold_d  = rd_entry[HW-1:0];
                end else begin
`ifdef SEQ_LOOP_EN
                    if (loop) begin
                        ptr_d   = '0;
                        instr_d = rd_entry[IW+HW-1:HW];
                        hold_d  = rd_entry[HW-1:0];
                    end else begin
                        state_d = StIdle;
                        ptr_d   = '0;
                        instr_d = '0;
                        done_d  = 1'b1;
                    end
`else
                    state_d = StIdle;
                    ptr_d   = '0;
                    instr_d = '0;
                    done_d  = 1'b1;
`endif
                end
            end
            default: begin
                state_d = StIdle;
                instr_d = '0;
            end
        endcase
    end

    // State registers; reset drives NOP onto the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            hold_q  <= '0;
            instr_q <= '0;
            done_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            done_q  <= done_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: a program model plus a per-cycle queue of
// expected instruction words built when a run is started.
module tb_instruction_sequencer;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned HW    = 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wr_valid = 1'b0;
    logic                   wr_ready;
    logic [IW-1:0]          wr_instr = '0;
    logic [HW-1:0]          wr_hold = '0;
    logic                   prog_clear = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   loop = 1'b0;
    logic [IW-1:0]          instruction;
    logic                   busy;
    logic                   done;
    logic [$clog2(DEPTH):0] prog_len;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] prog_i[$];
    logic [HW-1:0] prog_h[$];
    logic [IW-1:0] exp_q[$];

    instruction_sequencer #(.DEPTH(DEPTH), .IW(IW), .HW(HW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_instr   (wr_instr),
        .wr_hold    (wr_hold),
        .prog_clear (prog_clear),
        .start      (start),
        .abort      (abort),
`ifdef SEQ_LOOP_EN
        .loop       (loop),
`endif
        .instruction(instruction),
        .busy       (busy),
        .done       (done),
        .prog_len   (prog_len)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the following negedge.
    task automatic write_entry(input logic [IW-1:0] ins, input logic [HW-1:0] h);
        logic exp_rdy;
        wr_valid = 1'b1;
        wr_instr = ins;
        wr_hold  = h;
        #1;
        exp_rdy = (prog_i.size() < DEPTH);
        checks++;
        if (wr_ready !== exp_rdy) begin
            errors++;
            $display("FAIL wr_ready: got %b expected %b (len %0d)", wr_ready, exp_rdy,
                     prog_i.size());
        end
        if (exp_rdy) begin
            prog_i.push_back(ins);
            prog_h.push_back(h);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic check_len(input string tag);
        checks++;
        if (prog_len !== ($clog2(DEPTH)+1)'(prog_i.size())) begin
            errors++;
            $display("FAIL %s prog_len: got %0d expected %0d", tag, prog_len, prog_i.size());
        end
    endtask

    task automatic do_clear();
        prog_clear = 1'b1;
        @(negedge clk);
        prog_clear = 1'b0;
        prog_i.delete();
        prog_h.delete();
        check_len("clear");
    endtask

    task automatic write_n(input int n, input logic [HW-1:0] h);
        for (int i = 0; i < n; i++) begin
            write_entry(($urandom() << 1) | 32'd1, h);
        end
    endtask

    // Starts a run, re-asserts start on cycle 2 (must be ignored), optionally aborts.
    task automatic run_program(input string tag, input int abort_at);
        logic [IW-1:0] exp_v;
        int cyc;
        bit aborted;
        exp_q.delete();
        foreach (prog_i[i]) begin
            for (int k = 0; k <= int'(prog_h[i]); k++) exp_q.push_back(prog_i[i]);
        end
        cyc = 0;
        aborted = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            cyc++;
            checks++;
            if (instruction !== exp_v || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d: got instr %h busy %b done %b expected %h 1 0",
                         tag, cyc, instruction, busy, done, exp_v);
            end
            start = (cyc == 2);
            if (cyc == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                checks++;
                if (instruction !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort: got instr %h busy %b done %b expected 0 0 0",
                             tag, instruction, busy, done);
                end
                exp_q.delete();
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        if (!aborted) begin
            checks++;
            if (instruction !== '0 || busy !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL %s end: got instr %h busy %b done %b expected 0 0 1",
                         tag, instruction, busy, done);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s done pulse width: got done %b busy %b expected 0 0",
                         tag, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (instruction !== '0 || busy !== 1'b0 || done !== 1'b0 || prog_len !== '0
            || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got instr %h busy %b done %b len %0d rdy %b expected 0 0 0 0 1",
                     instruction, busy, done, prog_len, wr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        write_n(3, 8'd0);
        check_len("basic");
        run_program("basic", 0);
    endtask

    task automatic test_hold();
        do_clear();
        write_entry(32'hA5A5_0001, 8'd2);
        write_entry(32'h5A5A_0002, 8'd0);
        write_entry(32'h1234_5679, 8'd1);
        check_len("hold");
        run_program("hold", 0);
    endtask

    task automatic test_abort();
        do_clear();
        write_n(3, 8'd0);
        run_program("abort", 2);
        @(negedge clk);
        check_len("abort retain");
        run_program("replay", 0);
    endtask

    task automatic test_empty();
        write_entry(32'hDEAD_BEEF, 8'd0);
        prog_clear = 1'b1;
        wr_valid   = 1'b1;
        wr_instr   = 32'hCAFE_F00D;
        @(negedge clk);
        prog_clear = 1'b0;
        wr_valid   = 1'b0;
        prog_i.delete();
        prog_h.delete();
        check_len("clear+write");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || instruction !== '0) begin
            errors++;
            $display("FAIL empty start: got done %b busy %b instr %h expected 1 0 0",
                     done, busy, instruction);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || instruction !== '0) begin
            errors++;
            $display("FAIL empty after: got done %b busy %b instr %h expected 0 0 0",
                     done, busy, instruction);
        end
    endtask

    task automatic test_full();
        do_clear();
        write_n(DEPTH + 1, 8'd0);
        check_len("full");
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full wr_ready: got %b expected 0", wr_ready);
        end
        run_program("full", 0);
    endtask

    task automatic test_async_reset();
        do_clear();
        write_n(2, 8'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (instruction !== '0 || busy !== 1'b0 || prog_len !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async reset: got instr %h busy %b len %0d done %b expected 0 0 0 0",
                     instruction, busy, prog_len, done);
        end
        prog_i.delete();
        prog_h.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef SEQ_LOOP_EN
    task automatic test_loop();
        logic [IW-1:0] exp_v;
        do_clear();
        write_n(2, 8'd0);
        loop  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            exp_v = prog_i[c % 2];
            checks++;
            if (instruction !== exp_v || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL loop cycle %0d: got instr %h busy %b done %b expected %h 1 0",
                         c, instruction, busy, done, exp_v);
            end
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        loop  = 1'b0;
        checks++;
        if (busy !== 1'b0 || instruction !== '0) begin
            errors++;
            $display("FAIL loop abort: got busy %b instr %h expected 0 0", busy, instruction);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_abort();
        test_empty();
        test_full();
        test_async_reset();
`ifdef SEQ_LOOP_EN
        test_loop();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, program memory entries (power of two, 2..256).
REQ-002 SHALL have parameter IW, default 156, instruction width in bits.
REQ-003 SHALL have parameter HW, default 8, hold-count width in bits.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port wr_valid  input  1  host offers a program entry.
REQ-008 SHALL have port wr_ready  output  1  entry accepted when wr_valid&&wr_ready.
REQ-009 SHALL have port wr_instr  input  IW  instruction word to store.
REQ-010 SHALL have port wr_hold  input  HW  extra cycles to hold this instruction.
REQ-011 SHALL have port prog_clear  input  1  empty the program (IDLE only).
REQ-012 SHALL have port start  input  1  begin execution from entry 0.
REQ-013 SHALL have port abort  input  1  stop execution immediately.
REQ-014 SHALL have port instruction  output  IW  registered word driving the control unit.
REQ-015 SHALL have port busy  output  1  high while in RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at normal completion.
REQ-017 SHALL have port prog_len  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-018 SHALL implement states IDLE and RUN; reset state IDLE.
REQ-019 SHALL drive wr_ready = (state==IDLE) && (prog_len<DEPTH); a full or running program blocks writes.
REQ-020 SHALL, on accepted write, store {wr_instr,wr_hold} at index prog_len and increment prog_len next cycle.
REQ-021 SHALL, on prog_clear in IDLE, set prog_len to 0 next cycle; prog_clear overrides a same-cycle write; ignored in RUN.
REQ-022 SHALL, on start in IDLE with prog_len>0, enter RUN and present entry 0 on instruction the next cycle (latency 1).
REQ-023 SHALL hold each entry on instruction for wr_hold+1 consecutive cycles, then advance to the next index.
REQ-024 SHALL, after the final cycle of entry prog_len-1, return to IDLE next cycle with instruction=0, busy=0, done=1 for exactly one cycle.
REQ-025 SHALL, on start in IDLE with prog_len==0, pulse done next cycle without entering RUN or emitting any nonzero instruction.
REQ-026 SHALL ignore start while in RUN.
REQ-027 SHALL, on abort in RUN, return to IDLE next cycle with instruction=0, busy=0, done=0; abort has priority over start and advance.
REQ-028 SHALL drive instruction=0 (NOP) whenever in IDLE.
REQ-029 SHALL retain program contents across runs and aborts; only prog_clear or reset empties it.

Reset
REQ-030 SHALL, while rst_n is low, force state=IDLE, instruction=0, busy=0, done=0, prog_len=0, pointers and hold counter=0, independent of clk.
REQ-031 SHALL, on reset mid-RUN, discard execution and drive the control unit NOP immediately.
REQ-032 SHALL NOT require memory array contents to be reset.

Configuration
REQ-033 SHALL, with macro SEQ_LOOP_EN defined, add port loop  input  1; at end of last entry, if loop is high, present entry 0 next cycle with no done pulse and busy held high.
REQ-034 SHALL, with SEQ_LOOP_EN undefined, omit port loop and always complete per REQ-024.

Verification
REQ-035 SHALL cover: write 3 entries hold=0, start -> instruction = e0,e1,e2 on cycles 1-3, cycle 4 instruction=0, done=1, busy=0.
REQ-036 SHALL cover: entry hold=2 -> instruction constant for 3 cycles, then next entry.
REQ-037 SHALL cover: DEPTH=32 writes -> wr_ready=0 after 32nd acceptance, 33rd write not stored, prog_len=32.
REQ-038 SHALL cover: abort on 2nd cycle of run -> next cycle instruction=0, done=0; restart replays from e0.
REQ-039 SHALL cover: start with prog_len=0 -> done pulse next cycle, busy never high; prog_clear with wr_valid -> prog_len=0.
REQ-040 SHALL cover: rst_n low mid-run (async, between edges) -> instruction=0, busy=0 immediately; with SEQ_LOOP_EN and loop=1, 2 entries repeat e0,e1,e0,e1 with no done.
